// File: rtl/result_stream_source.sv
// Result FIFO feeding the Xillybus read_32 stream: one frame of frame_words words per file open.
// Optional protocol checker enabled by defining RESULT_STREAM_ERRCHK_EN.
module result_stream_source #(
  parameter int FIFO_AW = 6,
  parameter int FRAME_W = 24
) (
  input  logic               bus_clk,
  input  logic               bus_rst,
  input  logic               user_r_read_32_rden,
  input  logic               user_r_read_32_open,
  output logic [31:0]        user_r_read_32_data,
  output logic               user_r_read_32_empty,
  output logic               user_r_read_32_eof,
  input  logic [31:0]        res_data,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic [FRAME_W-1:0] frame_words,
  output logic               frame_done,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               err_sticky
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic                 open_q;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     level_q, level_d;
  logic [FRAME_W-1:0]   frame_len_q, frame_len_d, acc_cnt_q, acc_cnt_d;
  logic                 empty_q, empty_d, eof_q, eof_d, done_q, done_d;
  logic [31:0]          data_q;
  logic [31:0]          mem [DEPTH];
  logic                 push, pop, full, open_rise;

  assign full      = (level_q == (FIFO_AW+1)'(DEPTH));
  assign res_ready = (state_q == STREAM) && !full && (acc_cnt_q < frame_len_q);
  assign push      = res_valid & res_ready;
  assign pop       = user_r_read_32_rden & ~empty_q;
  assign open_rise = user_r_read_32_open & ~open_q;

  always_comb begin
    state_d     = state_q;
    frame_len_d = frame_len_q;
    acc_cnt_d   = acc_cnt_q;
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d     = level_q + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
    case (state_q)
      IDLE: begin
        if (open_rise) begin
          frame_len_d = frame_words;
          acc_cnt_d   = '0;
          state_d     = (frame_words == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (push) begin
          acc_cnt_d = acc_cnt_q + 1'b1;
          if (acc_cnt_q + 1'b1 == frame_len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (level_q == '0 && !pop) state_d = DONE;
      end
      default: ;
    endcase
    // Closing the file abandons the frame: unread words are simply dropped.
    if (!user_r_read_32_open) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
    empty_d = ((state_d != STREAM) && (state_d != DRAIN)) || (level_d == '0);
    eof_d   = (state_d == DONE);
    done_d  = (state_d == DONE) && (state_q != DONE);
  end

  always_ff @(posedge bus_clk) begin
    if (push) mem[wr_ptr_q] <= res_data;
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state_q     <= IDLE;
      open_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      frame_len_q <= '0;
      acc_cnt_q   <= '0;
      empty_q     <= 1'b1;
      eof_q       <= 1'b0;
      done_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      open_q      <= user_r_read_32_open;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      frame_len_q <= frame_len_d;
      acc_cnt_q   <= acc_cnt_d;
      empty_q     <= empty_d;
      eof_q       <= eof_d;
      done_q      <= done_d;
      if (pop) data_q <= mem[rd_ptr_q];
    end
  end

`ifdef RESULT_STREAM_ERRCHK_EN
  logic err_q;
  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      err_q <= 1'b0;
    end else if ((user_r_read_32_rden & empty_q) ||
                 (res_valid && state_q == DONE) ||
                 (open_rise && level_q != '0)) begin
      err_q <= 1'b1;
    end
  end
  assign err_sticky = err_q;
`else
  assign err_sticky = 1'b0;
`endif

  assign user_r_read_32_data  = data_q;
  assign user_r_read_32_empty = empty_q;
  assign user_r_read_32_eof   = eof_q;
  assign frame_done           = done_q;
  assign fifo_level           = level_q;

endmodule

// File: tb/tb_result_stream_source.sv
// Bench for result_stream_source: table of frame scenarios driven cycle by cycle against a
// queue-based reference model, plus hand-written reset and error sequences.
module tb_result_stream_source;

  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int S_IDLE = 0, S_STREAM = 1, S_DRAIN = 2, S_DONE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rden = 1'b0, open = 1'b0;
  logic [31:0] rdata;
  logic        empty, eof;
  logic [31:0] res_data = '0;
  logic        res_valid = 1'b0, res_ready;
  logic [23:0] frame_words = '0;
  logic        frame_done;
  logic [AW:0] fifo_level;
  logic        err_sticky;

  result_stream_source #(.FIFO_AW(AW), .FRAME_W(24)) dut (
    .bus_clk(clk), .bus_rst(rst),
    .user_r_read_32_rden(rden), .user_r_read_32_open(open),
    .user_r_read_32_data(rdata), .user_r_read_32_empty(empty), .user_r_read_32_eof(eof),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .frame_words(frame_words), .frame_done(frame_done),
    .fifo_level(fifo_level), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int          mstate = S_IDLE;
  int          mlen = 0, macc = 0;
  logic        mopen_q = 1'b0, mpulse = 1'b0, merr = 1'b0;
  logic [31:0] mdata = '0;
  logic [31:0] q[$];

  function automatic bit m_empty();
    return !(mstate == S_STREAM || mstate == S_DRAIN) || q.size() == 0;
  endfunction

  function automatic bit m_ready();
    return mstate == S_STREAM && q.size() < DEPTH && macc < mlen;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input logic o, input logic v, input logic [31:0] d,
                            input logic r, input logic rs);
    bit acc_push, do_pop;
    int lvl0;
    acc_push = v && m_ready();
    do_pop   = r && !m_empty();
    lvl0     = q.size();
    mpulse   = 1'b0;
    if (rs) begin
      mstate = S_IDLE; mlen = 0; macc = 0; mopen_q = 1'b0;
      merr = 1'b0; mdata = '0; q.delete();
      return;
    end
`ifdef RESULT_STREAM_ERRCHK_EN
    if ((r && m_empty()) || (v && mstate == S_DONE) || (o && !mopen_q && lvl0 != 0)) merr = 1'b1;
`endif
    if (do_pop) mdata = q.pop_front();
    if (acc_push) q.push_back(d);
    case (mstate)
      S_IDLE: if (o && !mopen_q) begin
        mlen = int'(frame_words);
        macc = 0;
        if (mlen == 0) begin mstate = S_DONE; mpulse = 1'b1; end
        else mstate = S_STREAM;
      end
      S_STREAM: if (acc_push) begin
        macc++;
        if (macc == mlen) mstate = S_DRAIN;
      end
      S_DRAIN: if (lvl0 == 0 && !do_pop) begin mstate = S_DONE; mpulse = 1'b1; end
      default: ;
    endcase
    if (!o) begin
      mstate = S_IDLE; q.delete(); mpulse = 1'b0;
    end
    mopen_q = o;
  endtask

  task automatic check_all();
    chk("empty", 32'(empty), 32'(m_empty()));
    chk("eof", 32'(eof), 32'(mstate == S_DONE));
    chk("level", 32'(fifo_level), 32'(q.size()));
    chk("res_ready", 32'(res_ready), 32'(m_ready()));
    chk("frame_done", 32'(frame_done), 32'(mpulse));
    chk("data", rdata, mdata);
    chk("err_sticky", 32'(err_sticky), 32'(merr));
  endtask

  // One clock: drive inputs away from the edge, advance model, sample on the falling edge.
  task automatic tick(input logic o, input logic v, input logic [31:0] d,
                      input logic r, input logic rs);
    open = o; res_valid = v; res_data = d; rden = r; rst = rs;
    model_step(o, v, d, r, rs);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    int          fw;
    int          n_offer;
    logic [31:0] base;
    int          rd_start, rd_stop, close_at, ncycles;
    int          exp_reads, exp_done;
  } row_t;

  row_t rows[8];

  initial begin
    int offered, good_reads, done_cnt;
    logic o, v, r, will_push;
    logic [31:0] d;

    rows[0] = '{4,  4,  32'hA000_0000, 7, 99, 20, 22, 4,  1};  // basic frame, read after fill
    rows[1] = '{6,  6,  32'hB000_0000, 8, 99, 30, 34, 6,  1};  // back-pressure at full
    rows[2] = '{6,  6,  32'hC000_0000, 4, 99, 30, 34, 6,  1};  // push+pop at level 2
    rows[3] = '{0,  1,  32'hD000_0000, 0, 0,  6,  8,  0,  1};  // empty frame
    rows[4] = '{8,  3,  32'hE000_0000, 3, 4,  5,  8,  1,  0};  // close mid-frame
    rows[5] = '{2,  2,  32'hF000_0000, 2, 99, 12, 14, 2,  1};  // reopen, fresh frame
    rows[6] = '{10, 10, 32'h0000_0077, 2, 99, 30, 32, 10, 1};  // streaming push/pop
    rows[7] = '{5,  7,  32'h1234_0000, 6, 99, 25, 27, 5,  1};  // excess valid after done

    @(negedge clk);
    tick(0, 0, '0, 0, 1);
    tick(0, 0, '0, 0, 1);
    tick(0, 0, '0, 0, 0);

    foreach (rows[i]) begin
      offered = 0; good_reads = 0; done_cnt = 0;
      frame_words = 24'(rows[i].fw);
      for (int cyc = 0; cyc < rows[i].ncycles; cyc++) begin
        o = (cyc >= 1) && (cyc < rows[i].close_at);
        v = (cyc >= 1) && (offered < rows[i].n_offer);
        d = rows[i].base + 32'(offered);
        r = (cyc >= rows[i].rd_start) && (cyc < rows[i].rd_stop) && !m_empty();
        will_push = v && m_ready();
        tick(o, v, d, r, 0);
        if (will_push) offered++;
        if (r && rdata === mdata) good_reads++;
        if (frame_done === 1'b1) done_cnt++;
      end
      chk("row_reads", 32'(good_reads), 32'(rows[i].exp_reads));
      chk("row_done_pulses", 32'(done_cnt), 32'(rows[i].exp_done));
      $display("row %0d fw=%0d reads=%0d done_pulses=%0d", i, rows[i].fw, good_reads, done_cnt);
    end

    // Reset in the middle of DRAIN with data already delivered.
    frame_words = 24'd3;
    tick(1, 0, '0, 0, 0);
    tick(1, 1, 32'h5500_0001, 0, 0);
    tick(1, 1, 32'h5500_0002, 1, 0);
    tick(1, 1, 32'h5500_0003, 0, 0);
    chk("drain_level", 32'(fifo_level), 32'd2);
    chk("drain_data", rdata, 32'h5500_0001);
    tick(1, 0, '0, 0, 1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_data", rdata, 32'd0);
    tick(0, 0, '0, 0, 0);
    $display("reset mid-drain sequence done");

    // Read strobe while empty: sticky error only in the checker build, cleared by reset.
    tick(0, 0, '0, 1, 0);
    tick(0, 0, '0, 0, 0);
    tick(0, 0, '0, 0, 0);
    tick(0, 0, '0, 0, 1);
    tick(0, 0, '0, 0, 0);
    $display("rden-while-empty sequence done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
